// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl
// Seven-segment controller for the board HEX digits. It captures one debug
// page into a shadow register on a load strobe or on an auto-cycle dwell
// tick. Each nibble is decoded to an active-low {g,f,e,d,c,b,a} pattern.
// Leading-zero blanking and per-digit blinking are applied on top of that,
// and the segment pins are driven from a register.

module hex_display_ctrl #(
    parameter  int DIGITS  = 6,
    parameter  int PAGES   = 4,
    parameter  int BLINK_W = 24,
    parameter  int DWELL_W = 26,
    localparam int PW      = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [PAGES*DIGITS*4-1:0] page_data,
    input  logic [PW-1:0]             page_sel,
    input  logic                      load,
    input  logic                      auto_en,
    input  logic                      lz_en,
    input  logic                      blink_en,
    input  logic [DIGITS-1:0]         blink_mask,
    output logic [PW-1:0]             page_idx,
    output logic [DIGITS*7-1:0]       seg
);

    // Nibble to active-low segment pattern, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            4'hF:    pat = 7'b0001110;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    logic [DIGITS*4-1:0] shadow_r;
    logic [PW-1:0]       page_idx_r;
    logic [BLINK_W-1:0]  blink_cnt_r;
    logic [DWELL_W-1:0]  dwell_cnt_r;
    logic [DIGITS*7-1:0] seg_r;

    logic [PW-1:0]       sel_idx_s;
    logic [PW-1:0]       next_idx_s;
    logic [DIGITS*4-1:0] sel_page_s;
    logic [DIGITS*4-1:0] next_page_s;
    logic                dwell_full_s;
    logic [DIGITS*7-1:0] seg_next_s;

    // Page selection: out-of-range selects fall back to page 0, auto step wraps
    always_comb begin
        sel_idx_s    = {PW{1'b0}};
        next_idx_s   = {PW{1'b0}};
        if (32'(page_sel) < PAGES) begin
            sel_idx_s = page_sel;
        end else begin
            sel_idx_s = {PW{1'b0}};
        end
        if (32'(page_idx_r) >= PAGES - 1) begin
            next_idx_s = {PW{1'b0}};
        end else begin
            next_idx_s = page_idx_r + PW'(1);
        end
        sel_page_s   = page_data[32'(sel_idx_s) * DIGITS * 4 +: DIGITS * 4];
        next_page_s  = page_data[32'(next_idx_s) * DIGITS * 4 +: DIGITS * 4];
        dwell_full_s = &dwell_cnt_r;
    end

    // Snapshot register, page index and dwell timer; load beats an auto tick
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shadow_r    <= {(DIGITS*4){1'b0}};
            page_idx_r  <= {PW{1'b0}};
            dwell_cnt_r <= {DWELL_W{1'b0}};
        end else if (load) begin
            shadow_r    <= sel_page_s;
            page_idx_r  <= sel_idx_s;
            dwell_cnt_r <= {DWELL_W{1'b0}};
        end else if (auto_en && dwell_full_s) begin
            shadow_r    <= next_page_s;
            page_idx_r  <= next_idx_s;
            dwell_cnt_r <= {DWELL_W{1'b0}};
        end else if (auto_en) begin
            shadow_r    <= shadow_r;
            page_idx_r  <= page_idx_r;
            dwell_cnt_r <= dwell_cnt_r + DWELL_W'(1);
        end else begin
            shadow_r    <= shadow_r;
            page_idx_r  <= page_idx_r;
            dwell_cnt_r <= dwell_cnt_r;
        end
    end

    // Free-running blink phase counter; its MSB is the blink phase
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            blink_cnt_r <= {BLINK_W{1'b0}};
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
        end
    end

    // Decode each digit, darkening leading zeros (top-down scan) and blinking digits
    always_comb begin
        logic nz_seen;
        logic dark;
        logic [3:0] nib;
        seg_next_s = {(DIGITS*7){1'b1}};
        nz_seen    = 1'b0;
        dark       = 1'b0;
        nib        = 4'h0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib     = shadow_r[4*i +: 4];
            nz_seen = nz_seen | (nib != 4'h0);
            dark    = (lz_en && !nz_seen && (i != 0)) ||
                      (blink_en && blink_cnt_r[BLINK_W-1] && blink_mask[i]);
            if (dark) begin
                seg_next_s[7*i +: 7] = 7'b1111111;
            end else begin
                seg_next_s[7*i +: 7] = hex_to_seg(nib);
            end
        end
    end

    // Segment output register; all digits dark while in reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            seg_r <= {(DIGITS*7){1'b1}};
        end else begin
            seg_r <= seg_next_s;
        end
    end

    assign page_idx = page_idx_r;
    assign seg      = seg_r;

endmodule
